// File: rtl/mem_ctrl_dual_pkg.sv
// Shared encodings for the dual-port refill responder: request codes, FSM states
// and the request-decode helper.
package mem_ctrl_dual_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // 2'b11 is treated exactly like idle.
  function automatic logic is_req(input logic [1:0] rw);
    return (rw == MEM_READ) || (rw == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_ctrl_dual_bram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, 1-cycle read.
// A read on the same edge as a write to that word returns the old contents.
module mem_bram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl_dual.sv
// Memory-side responder for the CPU's I-cache (port 1) and D-cache (port 0) refill
// ports: round-robin arbiter, IDLE/ACCESS/DONE FSM, latency counter, shared RAM.
module mem_ctrl_dual
  import mem_ctrl_dual_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rw_flag,
  input  logic [63:0] addr,
  input  logic [63:0] write_data,
  input  logic [7:0]  write_mask,
  output logic [63:0] read_data,
  output logic [1:0]  busy,
  output logic [1:0]  done
);

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              port_q, port_d;
  logic              wr_q, wr_d;
  logic              in_range_q, in_range_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [1:0]        busy_q, busy_d;
  logic [1:0]        done_q, done_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              req0, req1, gnt;
  logic [1:0]        g_rw;
  logic [31:0]       g_addr, g_wdata;
  logic [3:0]        g_mask;
  logic              g_in_range;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_lsb;

  assign req0 = is_req(rw_flag[1:0]);
  assign req1 = is_req(rw_flag[3:2]);

  // Round-robin only breaks ties; a lone requester always wins.
  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ~rr_last_q;
    end else begin
      gnt = req1;
    end
  end

  assign g_rw       = gnt ? rw_flag[3:2]     : rw_flag[1:0];
  assign g_addr     = gnt ? addr[63:32]       : addr[31:0];
  assign g_wdata    = gnt ? write_data[63:32] : write_data[31:0];
  assign g_mask     = gnt ? write_mask[7:4]   : write_mask[3:0];
  assign g_in_range = ~|g_addr[31:ADDR_W+2];
  assign unused_lsb = ^g_addr[1:0];

  // The RAM reads the incoming address at the grant edge so data is ready early.
  assign ram_addr = (state_q == ST_IDLE) ? g_addr[ADDR_W+1:2] : waddr_q;
  assign ram_we   = (rst && state_q == ST_ACCESS && first_q && wr_q && in_range_q)
                    ? mask_q : 4'b0000;

  mem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    port_d     = port_q;
    wr_d       = wr_q;
    in_range_d = in_range_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    rdata_d    = rdata_q;
    busy_d     = 2'b00;
    done_d     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d    = ST_ACCESS;
          port_d     = gnt;
          wr_d       = (g_rw == MEM_WRITE);
          in_range_d = g_in_range;
          waddr_d    = g_addr[ADDR_W+1:2];
          wdata_d    = g_wdata;
          mask_d     = g_mask;
          cnt_d      = 4'(MEM_LAT - 1);
          first_d    = 1'b1;
          if (req0 && req1) begin
            rr_last_d = gnt;
          end else begin
            rr_last_d = rr_last_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            if (port_q) begin
              rdata_d[63:32] = in_range_q ? ram_rdata : 32'h0;
            end else begin
              rdata_d[31:0]  = in_range_q ? ram_rdata : 32'h0;
            end
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != ST_IDLE) begin
      busy_d[port_d] = 1'b1;
    end else begin
      busy_d = 2'b00;
    end
    if (state_d == ST_DONE) begin
      done_d[port_d] = 1'b1;
    end else begin
      done_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'h0;
      mask_q     <= 4'h0;
      cnt_q      <= 4'h0;
      first_q    <= 1'b0;
      busy_q     <= 2'b00;
      done_q     <= 2'b00;
      rdata_q    <= 64'h0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      port_q     <= port_d;
      wr_q       <= wr_d;
      in_range_q <= in_range_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign read_data = rdata_q;

endmodule
